// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus start/busy sequencer feeding a UART transmitter.
module uart_tx_feeder #(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ack_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_ACK  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          ack_err_q, ack_err_d;
  logic          push, pop;

  // in_ready comes only from registered count, so a pop never frees a slot the same cycle
  assign in_ready   = count_q != (AW+1)'(DEPTH);
  assign push       = in_valid & in_ready;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign fifo_count = count_q;
  assign ack_err    = ack_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    ack_err_d  = ack_err_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0 && !tx_busy) begin
        pop        = 1'b1;
        tx_data_d  = mem_q[rd_q];
        tx_start_d = 1'b1;
        state_d    = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: if (tx_busy) state_d = WAIT_DONE;
        else if (cnt_q == TW'(ACK_TIMEOUT - 1)) begin
          ack_err_d = 1'b1;
          state_d   = IDLE;
        end else cnt_d = cnt_q + TW'(1);
      default: if (!tx_busy) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ack_err_q  <= 1'b0;
    end else begin
      wr_q       <= push ? wr_q + AW'(1) : wr_q;
      rd_q       <= pop ? rd_q + AW'(1) : rd_q;
      count_q    <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ack_err_q  <= ack_err_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized scenarios against a UART transmitter model and a byte-order scoreboard.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int AT    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx_start, tx_busy, ack_err;
  logic [7:0] tx_data;
  logic [4:0] fifo_count;
  logic [1:0] mode = 2'd0;  // 0: transmitter model, 1: busy forced high, 2: busy tied low

  logic       u_busy = 1'b0;
  logic [1:0] u_tick = 2'd0;
  logic [3:0] u_bit = 4'd0;
  logic [9:0] u_sh = 10'h3FF;
  logic [9:0] u_bits = 10'h000;

  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  logic [9:0] frame_q[$];
  int pass_n = 0;
  int total_n = 0;

  uart_tx_feeder #(.DEPTH(DEPTH), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .fifo_count(fifo_count),
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;
  assign tx_busy = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? 1'b0 : u_busy;

  // UART transmitter, 4 clocks per bit, bits recorded LSB-first as index 0..9
  always @(posedge clk) begin
    if (!u_busy) begin
      if (tx_start) begin
        u_sh   <= {1'b1, tx_data, 1'b0};
        u_busy <= 1'b1;
        u_tick <= 2'd0;
        u_bit  <= 4'd0;
      end
    end else if (u_tick == 2'd3) begin
      u_bits[u_bit] <= u_sh[0];
      u_sh   <= {1'b1, u_sh[9:1]};
      u_tick <= 2'd0;
      if (u_bit == 4'd9) begin
        u_busy <= 1'b0;
        frame_q.push_back({u_sh[0], u_bits[8:0]});
      end else u_bit <= u_bit + 4'd1;
    end else u_tick <= u_tick + 2'd1;
  end

  always @(posedge clk)
    if (tx_start) sent_q.push_back(tx_data);

  task automatic push_byte(input logic [7:0] b);
    int k = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && k < 2000) begin @(negedge clk); k++; end
    total_n++;
    if (!in_ready) $display("FAIL push_accept: in_ready=%b required 1", in_ready);
    else begin pass_n++; exp_q.push_back(b); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    int k = 0;
    while ((sent_q.size() < n || u_busy) && k < 3000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    total_n++;
    if (sent_q.size() != n) $display("FAIL drain_count: sent=%0d required %0d", sent_q.size(), n);
    else pass_n++;
  endtask

  task automatic clear_sb;
    exp_q.delete();
    sent_q.delete();
    frame_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total_n += 5;
    if (fifo_count !== 5'd0) $display("FAIL reset_count: got %0d required 0", fifo_count); else pass_n++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", in_ready); else pass_n++;
    if (tx_start !== 1'b0) $display("FAIL reset_start: got %b required 0", tx_start); else pass_n++;
    if (tx_data !== 8'h00) $display("FAIL reset_data: got %h required 00", tx_data); else pass_n++;
    if (ack_err !== 1'b0) $display("FAIL reset_ackerr: got %b required 0", ack_err); else pass_n++;
  endtask

  task automatic test_single;
    int lat;
    clear_sb();
    mode = 2'd0;
    in_data = 8'h41;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(8'h41);
    lat = 1;
    while (!tx_start && lat < 10) begin @(negedge clk); lat++; end
    total_n += 2;
    if (lat != 2) $display("FAIL single_latency: got %0d cycles required 2", lat); else pass_n++;
    if (tx_data !== 8'h41) $display("FAIL single_txdata: got %h required 41", tx_data); else pass_n++;
    wait_drain(1);
    total_n += 5;
    if (sent_q.size() != 1 || sent_q[0] !== 8'h41)
      $display("FAIL single_sent: got %0d bytes first %h required 1 byte 41", sent_q.size(), sent_q[0]);
    else pass_n++;
    if (frame_q.size() != 1 || frame_q[0] !== {1'b1, 8'h41, 1'b0})
      $display("FAIL single_frame: got %b required %b", frame_q[0], {1'b1, 8'h41, 1'b0});
    else pass_n++;
    if (fifo_count !== 5'd0) $display("FAIL single_count: got %0d required 0", fifo_count); else pass_n++;
    if (tx_data !== 8'h41) $display("FAIL single_hold: got %h required 41", tx_data); else pass_n++;
    if (tx_start !== 1'b0) $display("FAIL single_idle: tx_start=%b required 0", tx_start); else pass_n++;
  endtask

  task automatic test_full;
    clear_sb();
    mode = 2'd1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    total_n += 2;
    if (fifo_count !== 5'(DEPTH)) $display("FAIL full_count: got %0d required %0d", fifo_count, DEPTH); else pass_n++;
    if (in_ready !== 1'b0) $display("FAIL full_ready: got %b required 0", in_ready); else pass_n++;
    in_data = 8'hAA;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    total_n++;
    if (fifo_count !== 5'(DEPTH)) $display("FAIL full_ignore: got %0d required %0d", fifo_count, DEPTH); else pass_n++;
    mode = 2'd0;
    wait_drain(DEPTH);
    for (int i = 0; i < DEPTH && i < sent_q.size(); i++) begin
      total_n++;
      if (sent_q[i] !== exp_q[i]) $display("FAIL full_order[%0d]: got %h required %h", i, sent_q[i], exp_q[i]);
      else pass_n++;
    end
  endtask

  task automatic test_wrap;
    clear_sb();
    mode = 2'd0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) push_byte(8'($urandom_range(0, 255)));
      wait_drain(10 * (r + 1));
    end
    mode = 2'd1;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
    in_data = 8'($urandom_range(0, 255));
    in_valid = 1'b1;
    exp_q.push_back(in_data);
    mode = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    total_n += 2;
    if (fifo_count !== 5'd3) $display("FAIL wrap_pushpop_count: got %0d required 3", fifo_count); else pass_n++;
    if (tx_start !== 1'b1) $display("FAIL wrap_pushpop_start: got %b required 1", tx_start); else pass_n++;
    wait_drain(24);
    for (int i = 0; i < 24 && i < sent_q.size(); i++) begin
      total_n++;
      if (sent_q[i] !== exp_q[i]) $display("FAIL wrap_order[%0d]: got %h required %h", i, sent_q[i], exp_q[i]);
      else pass_n++;
    end
  endtask

  task automatic test_timeout;
    int k;
    clear_sb();
    mode = 2'd2;
    push_byte(8'h55);
    k = 0;
    while (!tx_start && k < 10) begin @(negedge clk); k++; end
    k = 0;
    while (!ack_err && k < 3 * AT) begin @(negedge clk); k++; end
    // START cycle, then ACK_TIMEOUT cycles in WAIT_ACK before the registered flag shows
    total_n += 2;
    if (k != AT + 1) $display("FAIL timeout_delay: ack_err after %0d cycles required %0d", k, AT + 1); else pass_n++;
    if (sent_q.size() != 1) $display("FAIL timeout_starts: got %0d required 1", sent_q.size()); else pass_n++;
    k = 0;
    while (u_busy && k < 200) begin @(negedge clk); k++; end
    mode = 2'd0;
    push_byte(8'h3C);
    wait_drain(2);
    total_n += 3;
    if (sent_q.size() < 2 || sent_q[1] !== 8'h3C) $display("FAIL timeout_next: got %h required 3c", sent_q[1]); else pass_n++;
    if (ack_err !== 1'b1) $display("FAIL timeout_sticky: got %b required 1", ack_err); else pass_n++;
    if (fifo_count !== 5'd0) $display("FAIL timeout_count: got %0d required 0", fifo_count); else pass_n++;
  endtask

  task automatic test_reset_mid;
    int k, sb, busy_starts;
    logic [7:0] b;
    clear_sb();
    mode = 2'd0;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
    k = 0;
    while (sent_q.size() < 1 && k < 100) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    total_n++;
    if (fifo_count !== 5'd3) $display("FAIL midrst_pre_count: got %0d required 3", fifo_count); else pass_n++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_n += 4;
    if (fifo_count !== 5'd0) $display("FAIL midrst_count: got %0d required 0", fifo_count); else pass_n++;
    if (tx_start !== 1'b0) $display("FAIL midrst_start: got %b required 0", tx_start); else pass_n++;
    if (ack_err !== 1'b0) $display("FAIL midrst_ackerr: got %b required 0", ack_err); else pass_n++;
    if (in_ready !== 1'b1) $display("FAIL midrst_ready: got %b required 1", in_ready); else pass_n++;
    sb = sent_q.size();
    b = 8'($urandom_range(0, 255));
    push_byte(b);
    busy_starts = 0;
    k = 0;
    while (u_busy && k < 200) begin
      if (sent_q.size() != sb) busy_starts++;
      @(negedge clk);
      k++;
    end
    total_n++;
    if (busy_starts != 0) $display("FAIL midrst_wait_busy: %0d starts while busy required 0", busy_starts); else pass_n++;
    wait_drain(sb + 1);
    repeat (60) @(negedge clk);
    total_n += 2;
    if (sent_q.size() != sb + 1) $display("FAIL midrst_lost: sent=%0d required %0d", sent_q.size(), sb + 1); else pass_n++;
    if (sent_q.size() > sb && sent_q[sb] !== b) $display("FAIL midrst_byte: got %h required %h", sent_q[sb], b);
    else pass_n++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
